// File: rtl/pnc_stmc_spike_dispatcher_if.sv
// Word-in / beat-out valid-ready bundle for the spike dispatcher.
// slave = dispatcher side, master = packet source plus beat sink.
`timescale 1ns/1ps
interface pnc_stmc_spike_dispatcher_if;
  logic [15:0] in_word;
  logic        in_valid;
  logic        in_ready;
  logic [14:0] out_data;
  logic [1:0]  out_type;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output in_word, in_valid, out_ready,
    input  in_ready, out_data, out_type, out_valid
  );

  modport slave (
    input  in_word, in_valid, out_ready,
    output in_ready, out_data, out_type, out_valid
  );
endinterface

// File: rtl/pnc_stmc_spike_dispatcher.sv
// Buffers PNC words, asks the STMC control unit per word, emits 0/1/2 beats.
// Ports: clk, rst (async low), sp (word in / beat out), cu_addr/cu_ctrl, drop_cnt, busy.
`timescale 1ns/1ps
module pnc_stmc_spike_dispatcher #(
  parameter int FIFO_DEPTH = 4,
  parameter int NA_W       = 7
) (
  input  logic                          clk,
  input  logic                          rst,
  pnc_stmc_spike_dispatcher_if.slave    sp,
  output logic [15:0]                   cu_addr,
  input  logic [1:0]                    cu_ctrl,
  output logic [7:0]                    drop_cnt,
  output logic                          busy
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = AW + 1;
  localparam int PADW = 15 - NA_W;

  typedef enum logic [2:0] {
    IDLE, WAIT, DECODE, SEND1, SEND2
  } state_t;

  state_t state, state_nx;

  logic [15:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic          full, empty;
  logic          push, pop, load;
  logic [15:0]   head;

  logic [14:0]   data_q;
  logic [1:0]    type_q;
  logic          two;
  logic          out_valid;

  logic [14:0]   first_na;
  logic [14:0]   second_na;

  assign full  = (count == CW'(FIFO_DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];
  assign push  = sp.in_valid & ~full;

  // The word under dispatch stays at the FIFO head until its last beat,
  // and cu_addr mirrors it, so the decode reads cu_addr.
  assign first_na  = {{PADW{1'b0}}, cu_addr[NA_W-1:0]};
  assign second_na = {{PADW{1'b0}}, cu_addr[2*NA_W-1:NA_W]};

  assign sp.in_ready  = ~full;
  assign sp.out_valid = out_valid;
  assign sp.out_data  = data_q;
  assign sp.out_type  = type_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:   if (!empty) state_nx = WAIT;
      WAIT:   state_nx = DECODE;
      DECODE: begin
        case (cu_ctrl)
          2'b10:   state_nx = DECODE;
          2'b00:   state_nx = IDLE;
          default: state_nx = SEND1;
        endcase
      end
      SEND1:  if (sp.out_ready) state_nx = two ? SEND2 : IDLE;
      SEND2:  if (sp.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    out_valid = 1'b0;
    pop       = 1'b0;
    load      = 1'b0;
    unique case (state)
      IDLE:   load = ~empty;
      WAIT:   ;
      DECODE: pop = (cu_ctrl == 2'b00);
      SEND1: begin
        out_valid = 1'b1;
        pop       = sp.out_ready & ~two;
      end
      SEND2: begin
        out_valid = 1'b1;
        pop       = sp.out_ready;
      end
      default: ;
    endcase
    busy = (state != IDLE) | ~empty;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= sp.in_word;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cu_addr  <= '0;
      data_q   <= '0;
      type_q   <= '0;
      two      <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (load) cu_addr <= head;
      if (state == DECODE) begin
        case (cu_ctrl)
          2'b00: begin
            if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
          end
          2'b01: begin
            two <= 1'b0;
            if (cu_addr[15]) begin
              type_q <= 2'b10;
              data_q <= cu_addr[14:0];
            end else if (cu_addr[14]) begin
              type_q <= 2'b01;
              data_q <= {1'b0, cu_addr[13:0]};
            end else begin
              type_q <= 2'b00;
              data_q <= first_na;
            end
          end
          2'b11: begin
            two    <= 1'b1;
            type_q <= 2'b00;
            data_q <= first_na;
          end
          default: ;
        endcase
      end
      if (state == SEND1 && sp.out_ready && two) data_q <= second_na;
    end
  end

endmodule

// File: tb/tb_pnc_stmc_spike_dispatcher.sv
// Bench for pnc_stmc_spike_dispatcher: CU model, beat scoreboard, random traffic.
// Drives sp as master, checks beats, stalls, latency, throughput and drop counting.
`timescale 1ns/1ps
module tb_pnc_stmc_spike_dispatcher;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cu_addr;
  logic [1:0]  cu_ctrl;
  logic [7:0]  drop_cnt;
  logic        busy;
  logic        cu_hold;

  pnc_stmc_spike_dispatcher_if sp ();

  pnc_stmc_spike_dispatcher dut (
    .clk      (clk),
    .rst      (rst),
    .sp       (sp.slave),
    .cu_addr  (cu_addr),
    .cu_ctrl  (cu_ctrl),
    .drop_cnt (drop_cnt),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;
  int model_drops = 0;
  logic [16:0] exp_q [$];
  int          beat_cyc [$];
  logic        prev_hold = 1'b0;
  logic [16:0] prev_beat = '0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Control-unit decision table used by this bench.
  function automatic logic [1:0] cu_fn(input logic [15:0] w);
    if (w[15] || w[14])      return 2'b01;
    else if (w[6:0] == 7'd0) return 2'b00;
    else if (w[13:7] != 7'd0) return 2'b11;
    else                     return 2'b01;
  endfunction

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    cu_ctrl <= cu_hold ? 2'b10 : cu_fn(cu_addr);
  end

  function automatic void model_push(input logic [15:0] w);
    logic [1:0] c;
    c = cu_fn(w);
    if (c == 2'b00) model_drops++;
    else if (c == 2'b11) begin
      exp_q.push_back({2'b00, 8'd0, w[6:0]});
      exp_q.push_back({2'b00, 8'd0, w[13:7]});
    end else if (w[15]) exp_q.push_back({2'b10, w[14:0]});
    else if (w[14])     exp_q.push_back({2'b01, 1'b0, w[13:0]});
    else                exp_q.push_back({2'b00, 8'd0, w[6:0]});
  endfunction

  function automatic int sat(input int n);
    return (n > 255) ? 255 : n;
  endfunction

  function automatic void model_clear();
    exp_q.delete();
    model_drops = 0;
    prev_hold   = 1'b0;
  endfunction

  always @(negedge clk) begin
    if (!rst) prev_hold = 1'b0;
    else begin
      if (prev_hold) begin
        chk("hold_valid", 32'(sp.out_valid), 32'd1);
        chk("hold_beat", 32'({sp.out_type, sp.out_data}), 32'(prev_beat));
      end
      if (sp.in_valid && sp.in_ready) model_push(sp.in_word);
      if (sp.out_valid && sp.out_ready) begin
        beat_cyc.push_back(cyc);
        if (exp_q.size() == 0) chk("beat_unexpected", 32'd1, 32'd0);
        else chk("beat", 32'({sp.out_type, sp.out_data}),
                 32'(exp_q.pop_front()));
      end
      prev_hold = sp.out_valid && !sp.out_ready;
      prev_beat = {sp.out_type, sp.out_data};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [15:0] w);
    bit ok;
    int n;
    n = 0;
    sp.in_word  = w;
    sp.in_valid = 1'b1;
    do begin
      @(negedge clk);
      ok = sp.in_ready;
      tick();
      n++;
    end while (!ok && n < 500);
    sp.in_valid = 1'b0;
    if (!ok) chk("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sp.out_valid && n < 200);
    if (!sp.out_valid) chk(tag, 32'd0, 32'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    sp.in_valid = 1'b0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || exp_q.size() != 0) && n < 3000);
    if (busy) chk("drain_timeout", 32'd1, 32'd0);
    chk("drain_queue", 32'(exp_q.size()), 32'd0);
    chk("drop_cnt", 32'(drop_cnt), 32'(sat(model_drops)));
    tick();
  endtask

  initial begin
    rst          = 1'b0;
    cu_hold      = 1'b0;
    sp.in_valid  = 1'b0;
    sp.in_word   = '0;
    sp.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(sp.out_valid), 32'd0);
    chk("rst_cu_addr", 32'(cu_addr), 32'd0);
    chk("rst_out_data", 32'(sp.out_data), 32'd0);
    chk("rst_out_type", 32'(sp.out_type), 32'd0);
    chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    chk("rst_in_ready", 32'(sp.in_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    tick();
    rst = 1'b1;
    tick();

    // Reset in the middle of SEND1.
    push_word(16'h0005);
    wait_valid("t1_wait");
    #2;
    rst = 1'b0;
    model_clear();
    #1;
    chk("t1_async_valid", 32'(sp.out_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("t1_in_ready", 32'(sp.in_ready), 32'd1);
    chk("t1_drop_cnt", 32'(drop_cnt), 32'd0);
    chk("t1_busy", 32'(busy), 32'd0);
    tick();
    sp.out_ready = 1'b1;
    repeat (10) tick();
    chk("t1_no_beat", 32'(sp.out_valid), 32'd0);

    // Latency: accepted at end of cycle 0, valid in cycle 4.
    sp.in_word  = 16'h0005;
    sp.in_valid = 1'b1;
    tick();
    sp.in_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("t2_lat_c%0d", k), 32'(sp.out_valid), 32'(k == 4));
    end
    chk("t2_data", 32'(sp.out_data), 32'h0005);
    chk("t2_type", 32'(sp.out_type), 32'd0);
    tick();
    drain();

    // Two-beat word, beats in consecutive cycles.
    push_word(16'h0283);
    wait_valid("t3_wait");
    chk("t3_d1", 32'({sp.out_type, sp.out_data}), 32'h3);
    @(negedge clk);
    chk("t3_v2", 32'(sp.out_valid), 32'd1);
    chk("t3_d2", 32'({sp.out_type, sp.out_data}), 32'h5);
    tick();
    drain();

    // Param and richclub words.
    push_word(16'h8123);
    push_word(16'h4011);
    wait_valid("t4_wait1");
    chk("t4_type1", 32'(sp.out_type), 32'h2);
    chk("t4_data1", 32'(sp.out_data), 32'h0123);
    tick();
    wait_valid("t4_wait2");
    chk("t4_type2", 32'(sp.out_type), 32'h1);
    chk("t4_data2", 32'(sp.out_data), 32'h0011);
    tick();
    drain();

    // Throughput with out_ready held high.
    beat_cyc.delete();
    push_word(16'h0001);
    push_word(16'h0002);
    push_word(16'h0003);
    drain();
    chk("tp1_beats", 32'(beat_cyc.size()), 32'd3);
    if (beat_cyc.size() == 3) begin
      chk("tp1_gap_a", 32'(beat_cyc[1] - beat_cyc[0]), 32'd4);
      chk("tp1_gap_b", 32'(beat_cyc[2] - beat_cyc[1]), 32'd4);
    end
    beat_cyc.delete();
    push_word(16'h0283);
    push_word(16'h0285);
    drain();
    chk("tp2_beats", 32'(beat_cyc.size()), 32'd4);
    if (beat_cyc.size() == 4) begin
      chk("tp2_pair", 32'(beat_cyc[1] - beat_cyc[0]), 32'd1);
      chk("tp2_gap", 32'(beat_cyc[2] - beat_cyc[0]), 32'd5);
    end

    // Drop on ctrl 00.
    push_word(16'h0000);
    drain();
    chk("t5_drop_one", 32'(drop_cnt), 32'd1);

    // Back-pressure with the buffer filled.
    sp.out_ready = 1'b0;
    push_word(16'h0011);
    push_word(16'h0012);
    push_word(16'h8013);
    push_word(16'h4014);
    sp.in_word  = 16'h0283;
    sp.in_valid = 1'b1;
    repeat (6) tick();
    @(negedge clk);
    chk("t6_in_ready", 32'(sp.in_ready), 32'd0);
    chk("t6_held_valid", 32'(sp.out_valid), 32'd1);
    chk("t6_held_data", 32'(sp.out_data), 32'h0011);
    tick();
    sp.out_ready = 1'b1;
    push_word(16'h0283);
    drain();

    // Random traffic with CU-reset stalls.
    for (int i = 0; i < 3000; i++) begin
      bit acc;
      logic [15:0] w;
      @(negedge clk);
      acc = sp.in_valid && sp.in_ready;
      tick();
      if (acc || !sp.in_valid) begin
        if ($urandom_range(0, 2) != 0) begin
          w = 16'($urandom);
          if ($urandom_range(0, 5) == 0) begin
            w[15:14] = 2'b00;
            w[6:0]   = 7'd0;
          end
          sp.in_word  = w;
          sp.in_valid = 1'b1;
        end else sp.in_valid = 1'b0;
      end
      sp.out_ready = ($urandom_range(0, 9) < 7);
      cu_hold      = ($urandom_range(0, 19) == 0);
    end
    cu_hold      = 1'b0;
    sp.out_ready = 1'b1;
    drain();

    // Saturation of the drop counter.
    for (int i = 0; i < 300; i++) push_word(16'h0000);
    drain();
    chk("t5_drop_sat", 32'(drop_cnt), 32'd255);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
